// File: rtl/cal_pkg.sv
// Shared types and constants for the calculator command sequencer.
// Covers FSM states, opcodes, ASCII byte values and error codes.
package cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPA   = 2'd1,
        ST_OPB   = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
    localparam logic [2:0] ERR_DIG_OVF  = 3'd2;
    localparam logic [2:0] ERR_OVERRUN  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    // Used at elaboration to prove the largest DIG_MAX-digit value fits OP_W bits.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/cal_ascii_class.sv
// Combinational classifier sorting one received byte into the parser's
// byte classes: digit, operator, terminator, blank or bad.
import cal_pkg::*;

module cal_ascii_class (
    input  logic [7:0] rx_data,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_op,
    output logic [1:0] op,
    output logic       is_term,
    output logic       is_blank,
    output logic       is_bad
);

    always_comb begin
        is_digit = (rx_data >= ASC_0) && (rx_data <= ASC_9);
        digit    = rx_data[3:0];
        is_op    = 1'b0;
        op       = OP_ADD;
        case (rx_data)
            ASC_PLUS:  begin is_op = 1'b1; op = OP_ADD; end
            ASC_MINUS: begin is_op = 1'b1; op = OP_SUB; end
            ASC_STAR:  begin is_op = 1'b1; op = OP_MUL; end
            ASC_SLASH: begin is_op = 1'b1; op = OP_DIV; end
            default:   ;
        endcase
        is_term  = (rx_data == ASC_EQ) || (rx_data == ASC_CR);
        is_blank = (rx_data == ASC_SP) || (rx_data == ASC_LF);
        is_bad   = !(is_digit || is_op || is_term || is_blank);
    end

endmodule

// File: rtl/cal_cmd_ctrl.sv
// Parses "A<op>B=" from the UART byte stream and issues one ALU command per expression.
// Optional idle timeout in the operand states is built when CAL_CMD_TIMEOUT_EN is defined.
import cal_pkg::*;

module cal_cmd_ctrl #(
    parameter int DIG_MAX = 4,
    parameter int OP_W    = 14,
    parameter int TO_CYC  = 100000
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [OP_W-1:0] cmd_a,
    output logic [OP_W-1:0] cmd_b,
    output logic [1:0]      cmd_op,
    output logic            err,
    output logic [2:0]      err_code,
    output logic            busy
);

    localparam int CNT_W = $clog2(DIG_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIG_MAX);

    // Accumulation truncates to OP_W, so every DIG_MAX-digit value must fit.
    if (pow10(DIG_MAX) - 64'd1 >= (64'd1 << OP_W)) begin : g_bad_op_w
        $error("cal_cmd_ctrl: OP_W too narrow for DIG_MAX decimal digits");
    end
    if (TO_CYC < 2) begin : g_bad_to_cyc
        $error("cal_cmd_ctrl: TO_CYC must be at least 2");
    end

    logic            is_digit, is_op, is_term, is_blank, is_bad;
    logic [3:0]      digit;
    logic [1:0]      op;

    cal_ascii_class u_class (
        .rx_data  (rx_data),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .op       (op),
        .is_term  (is_term),
        .is_blank (is_blank),
        .is_bad   (is_bad)
    );

    state_t          state_q, state_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic [OP_W-1:0] acc_in, acc_next;
    logic            to_expire;

`ifdef CAL_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            in_operand;

    assign in_operand = (state_q == ST_OPA) || (state_q == ST_OPB);
    assign to_expire  = in_operand && !rx_valid && (to_cnt_q == TO_LAST);

    // Counts silent cycles while an operand is open; any byte restarts it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_q <= '0;
        end else if (in_operand && !rx_valid && !to_expire) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // acc*10 + d as two shifts and an add; the same datapath serves both operands.
    assign acc_in   = (state_q == ST_OPB) ? b_q : a_q;
    assign acc_next = (acc_in << 3) + (acc_in << 1) + OP_W'(digit);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && is_digit) begin
                    a_d     = OP_W'(digit);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_OPA;
                end else if (rx_valid && (is_op || is_term || is_bad)) begin
                    err_d  = 1'b1;
                    code_d = ERR_BAD_CHAR;
                end
            end
            ST_OPA: begin
                if (rx_valid && is_digit) begin
                    if (cnt_q < CNT_MAX) begin
                        a_d   = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_DIG_OVF;
                        state_d = ST_IDLE;
                    end
                end else if (rx_valid && is_op) begin
                    op_d    = op;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_OPB;
                end else if (rx_valid && (is_term || is_bad)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_BAD_CHAR;
                    state_d = ST_IDLE;
                end
            end
            ST_OPB: begin
                if (rx_valid && is_digit) begin
                    if (cnt_q < CNT_MAX) begin
                        b_d   = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_DIG_OVF;
                        state_d = ST_IDLE;
                    end
                end else if (rx_valid && is_term && (cnt_q != '0)) begin
                    state_d = ST_ISSUE;
                end else if (rx_valid && (is_term || is_op || is_bad)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_BAD_CHAR;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A byte arriving here is lost, but a same-cycle handshake still completes.
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_expire) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = ST_IDLE;
        end
    end

    assign cmd_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_a     = a_q;
    assign cmd_b     = b_q;
    assign cmd_op    = op_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_cal_cmd_ctrl.sv
// Scoreboard bench for cal_cmd_ctrl: directed expressions plus random byte streams.
// Define CAL_CMD_TIMEOUT_EN for both RTL and bench to exercise the timeout path.
module tb_cal_cmd_ctrl;

    localparam int DIG_MAX = 4;
    localparam int OP_W    = 14;
    localparam int TO_CYC  = 50;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_a;
    logic [OP_W-1:0] cmd_b;
    logic [1:0]      cmd_op;
    logic            err;
    logic [2:0]      err_code;
    logic            busy;

    cal_cmd_ctrl #(.DIG_MAX(DIG_MAX), .OP_W(OP_W), .TO_CYC(TO_CYC)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
    } cmd_t;

    cmd_t exp_cmd[$];
    int   exp_err[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference parser: phase 0 waiting for A, 1 reading A, 2 reading B, 3 command held.
    int m_phase = 0;
    int m_a = 0, m_b = 0, m_op = 0, m_nd = 0, m_last = 0;

    task automatic push_err(input int code);
        exp_err.push_back(code);
        m_last = code;
    endtask

    task automatic model_byte(input logic [7:0] c);
        bit   dig;
        int   opi;
        bit   term;
        cmd_t cmd;
        dig  = (c >= "0") && (c <= "9");
        term = (c == "=") || (c == 8'h0D);
        opi  = (c == "+") ? 0 : (c == "-") ? 1 : (c == "*") ? 2 : (c == "/") ? 3 : -1;
        if (m_phase == 3) begin
            push_err(3);
        end else if (c == " " || c == 8'h0A) begin
            // blanks carry no meaning outside a held command
        end else if (m_phase == 0) begin
            if (dig) begin
                m_a = int'(c) - 48; m_nd = 1; m_phase = 1;
            end else begin
                push_err(1);
            end
        end else if (dig) begin
            if (m_nd == DIG_MAX) begin
                push_err(2); m_phase = 0;
            end else if (m_phase == 1) begin
                m_a = m_a * 10 + (int'(c) - 48); m_nd++;
            end else begin
                m_b = m_b * 10 + (int'(c) - 48); m_nd++;
            end
        end else if (m_phase == 1 && opi >= 0) begin
            m_op = opi; m_b = 0; m_nd = 0; m_phase = 2;
        end else if (m_phase == 2 && term && m_nd > 0) begin
            cmd.a = m_a; cmd.b = m_b; cmd.op = m_op;
            exp_cmd.push_back(cmd);
            m_phase = 3;
        end else begin
            push_err(1); m_phase = 0;
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] c);
        rx_valid = 1'b1;
        rx_data  = c;
        model_byte(c);
        tick();
        rx_valid = 1'b0;
    endtask

    // Hold the command for stall cycles, optionally with overrun bytes, then accept it.
    task automatic do_issue(input int stall, input bit ovr_mid, input bit ovr_hs);
        check_output("cmd_valid_latency", int'(cmd_valid), 1);
        cmd_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (ovr_mid && i == stall / 2) apply_stimulus(($urandom_range(0, 1) == 0) ? 8'h20 : "1");
            else tick();
        end
        cmd_ready = 1'b1;
        if (ovr_hs) apply_stimulus(8'h0A);
        else tick();
        check_output("idle_after_handshake", int'(busy), 0);
        cmd_ready = 1'b0;
        m_phase   = 0;
    endtask

    task automatic send_str(input string s, input int stall, input bit ovr_mid);
        for (int i = 0; i < s.len(); i++) begin
            apply_stimulus(s[i]);
            if (m_phase == 3) do_issue(stall, ovr_mid, 1'b0);
            else repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    function automatic logic [7:0] op_char(input int i);
        case (i)
            0:       return "+";
            1:       return "-";
            2:       return "*";
            default: return "/";
        endcase
    endfunction

    task automatic random_expr();
        logic [7:0] q[$];
        int na, nb;
        na = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
        nb = ($urandom_range(0, 9) == 0) ? 0 : (($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4));
        for (int i = 0; i < na; i++) begin
            if ($urandom_range(0, 9) == 0) q.push_back(8'h20);
            q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
        q.push_back(op_char($urandom_range(0, 3)));
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 9) == 0) q.push_back(8'h0A);
            q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
        if ($urandom_range(0, 9) == 0) q.insert($urandom_range(0, q.size() - 1), "x");
        q.push_back(($urandom_range(0, 1) == 0) ? 8'h3D : 8'h0D);
        foreach (q[i]) begin
            apply_stimulus(q[i]);
            if (m_phase == 3) do_issue($urandom_range(0, 4), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            else repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // Monitor: compare presented commands and error pulses against the scoreboard.
    always @(negedge clk) begin
        if (n_rst) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    vectors++; errors++;
                    $display("[TB] FAIL cmd_unexpected: got a=%0d b=%0d op=%0d, expected no command", cmd_a, cmd_b, cmd_op);
                end else begin
                    check_output("cmd_a", int'(cmd_a), exp_cmd[0].a);
                    check_output("cmd_b", int'(cmd_b), exp_cmd[0].b);
                    check_output("cmd_op", int'(cmd_op), exp_cmd[0].op);
                    if (cmd_ready) void'(exp_cmd.pop_front());
                end
            end
            if (err) begin
                if (exp_err.size() == 0) begin
                    vectors++; errors++;
                    $display("[TB] FAIL err_unexpected: got code %0d, expected no error", err_code);
                end else begin
                    check_output("err_code", int'(err_code), exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        n_rst     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();
        check_output("rst_cmd_valid", int'(cmd_valid), 0);
        check_output("rst_cmd_a", int'(cmd_a), 0);
        check_output("rst_cmd_b", int'(cmd_b), 0);
        check_output("rst_cmd_op", int'(cmd_op), 0);
        check_output("rst_err", int'(err), 0);
        check_output("rst_err_code", int'(err_code), 0);
        check_output("rst_busy", int'(busy), 0);

        $display("[TB] basic add with ready held high");
        cmd_ready = 1'b1;
        send_str("12+34=", 0, 1'b0);
        $display("[TB] long operands, 20-cycle stall");
        send_str("9999*9999\r", 20, 1'b0);
        $display("[TB] digit overflow then recovery");
        send_str("12345", 0, 1'b0);
        send_str("7/2=", 2, 1'b0);
        $display("[TB] missing operand B and bad char in idle");
        send_str("5+=", 0, 1'b0);
        check_output("busy_after_bad_term", int'(busy), 0);
        send_str("x", 0, 1'b0);
        $display("[TB] overrun during stall");
        send_str("5+3=", 6, 1'b1);
        send_str(" 10 - 4 =", 1, 1'b0);

        $display("[TB] reset mid-expression");
        send_str("12+", 0, 1'b0);
        n_rst = 1'b0;
        tick();
        n_rst   = 1'b1;
        m_phase = 0;
        m_last  = 0;
        tick();
        check_output("midrst_busy", int'(busy), 0);
        check_output("midrst_cmd_a", int'(cmd_a), 0);
        send_str("3=", 0, 1'b0);
        send_str("4+5=", 0, 1'b0);

        $display("[TB] random expressions");
        for (int n = 0; n < 60; n++) random_expr();

        $display("[TB] idle in operand B");
        apply_stimulus("8");
        apply_stimulus("-");
`ifdef CAL_CMD_TIMEOUT_EN
        push_err(4);
        m_phase = 0;
        repeat (TO_CYC) tick();
        check_output("busy_after_timeout", int'(busy), 0);
`else
        repeat (TO_CYC) tick();
        check_output("busy_no_timeout", int'(busy), 1);
`endif
        send_str("1=", 0, 1'b0);

        repeat (4) tick();
        check_output("cmd_queue_drained", exp_cmd.size(), 0);
        check_output("err_queue_drained", exp_err.size(), 0);
        check_output("err_code_hold", int'(err_code), m_last);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
